// File: rtl/adder_fu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_fu_pipe
// Brief    : Lane-split add/adc/sub/sat-add unit with valid/ready input and an
//            output result FIFO.
// Revision : 1.0
// ============================================================================
module adder_fu_pipe #(
  parameter int WIDTH = 16,
  parameter int LANES = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             on_off,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [LANES-1:0] carry_in,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [LANES-1:0] carry_out,
  output logic             ack
);

  localparam int LW = WIDTH / LANES;
  localparam int EW = WIDTH + LANES;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [PW-1:0] c_last  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] w_res;
  logic [LANES-1:0] w_co;

  // Subtract is a + ~b + 1, so the lane carry-out doubles as the no-borrow flag.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [LW-1:0] w_a;
    logic [LW-1:0] w_b;
    logic          w_cin;
    logic [LW:0]   w_sum;

    assign w_a   = a[k*LW +: LW];
    assign w_b   = (op == 2'b10) ? ~b[k*LW +: LW] : b[k*LW +: LW];
    assign w_cin = (op == 2'b01) ? carry_in[k] : (op == 2'b10);
    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{LW{1'b0}}, w_cin};

    assign w_co[k]            = w_sum[LW];
    assign w_res[k*LW +: LW]  = ((op == 2'b11) && w_sum[LW]) ? {LW{1'b1}} : w_sum[LW-1:0];
  end

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  logic          w_push;
  logic          w_pop;

  assign out_valid = on_off && (count_q != '0);
  assign w_pop     = out_valid && out_ready;
  assign in_ready  = reset && on_off && ((count_q < c_depth) || w_pop);
  assign w_push    = in_valid && in_ready;

  assign {c, carry_out} = out_valid ? mem_q[rd_ptr_q] : '0;
  assign ack            = ack_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ack_d    = 1'b0;
    if (!on_off) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      ack_d = w_push;
      if (w_push) begin
        wr_ptr_d = (wr_ptr_q == c_last) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_d = (rd_ptr_q == c_last) ? '0 : rd_ptr_q + 1'b1;
      end
      if (w_push && !w_pop) begin
        count_d = count_q + 1'b1;
      end else if (!w_push && w_pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
    end
  end

  // Storage needs no reset: the read port is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {w_res, w_co};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_fu_pipe.sv
`default_nettype none
// Scoreboard bench for adder_fu_pipe: WIDTH=16, LANES=2, DEPTH=2.
module tb_adder_fu_pipe;

  localparam int W  = 16;
  localparam int L  = 2;
  localparam int D  = 2;
  localparam int LW = W / L;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         on_off = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [L-1:0] carry_in = '0;
  logic [1:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] c;
  logic [L-1:0] carry_out;
  logic         ack;

  adder_fu_pipe #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .on_off    (on_off),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .carry_out (carry_out),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  logic exp_ack = 1'b0;
  logic [W+L-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Reference arithmetic on plain integers, lane by lane.
  function automatic logic [W+L-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [L-1:0] ci, input logic [1:0] o);
    logic [W-1:0] r;
    logic [L-1:0] co;
    r  = '0;
    co = '0;
    for (int k = 0; k < L; k++) begin
      int ax, by, s;
      ax = int'(x[k*LW +: LW]);
      by = int'(y[k*LW +: LW]);
      case (o)
        2'b00:   s = ax + by;
        2'b01:   s = ax + by + int'(ci[k]);
        2'b10:   s = ax - by;
        default: s = ax + by;
      endcase
      if (o == 2'b10) begin
        co[k] = (ax >= by);
        s = s + (1 << LW);
      end else begin
        co[k] = (s >= (1 << LW));
      end
      if (o == 2'b11 && co[k]) s = (1 << LW) - 1;
      r[k*LW +: LW] = LW'(s % (1 << LW));
    end
    return {r, co};
  endfunction

  // Producer side: record the expected result of every accepted operation.
  always @(posedge clk) begin
    logic acc;
    acc = reset && on_off && in_valid && (exp_q.size() < D);
    exp_ack = acc;
    if (reset && !on_off) exp_q.delete();
    if (acc) begin
      exp_q.push_back(model(a, b, carry_in, op));
      n_acc++;
    end
  end

  always @(negedge reset) begin
    exp_q.delete();
    exp_ack = 1'b0;
  end

  // Monitor: compare what the DUT presents against the model state.
  always @(negedge clk) begin
    logic [W+L-1:0] head;
    logic           have;
    have = on_off && (exp_q.size() > 0);
    chk("out_valid", out_valid, have);
    chk("in_ready", in_ready,
        reset && on_off && ((exp_q.size() < D) || (exp_q.size() > 0 && out_ready)));
    chk("ack", ack, exp_ack);
    if (have) begin
      head = exp_q[0];
      chk("c", c, head[W+L-1:L]);
      chk("carry_out", carry_out, head[L-1:0]);
      if (out_ready) void'(exp_q.pop_front());
    end else begin
      chk("idle_out", {carry_out, c}, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    a        = W'($urandom);
    b        = W'($urandom);
    carry_in = L'($urandom);
    op       = 2'($urandom);
  endtask

  // Issue one op into an empty FIFO and check the literal result next cycle.
  task automatic send_check(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input logic [L-1:0] ci, input logic [1:0] o,
                            input logic [W-1:0] want_c, input logic [L-1:0] want_co);
    bit got;
    a = xa; b = xb; carry_in = ci; op = o; in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      chk({name, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_c"}, c, want_c);
    chk({name, "_co"}, carry_out, want_co);
    chk({name, "_ack"}, ack, 1);
    @(negedge clk);
    chk({name, "_ack_drop"}, ack, 0);
    #1;
  endtask

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_c", c, 0);
    reset = 1'b1;
    step();

    send_check("adc_wrap", 16'hFFFF, 16'h0000, 2'b11, 2'b01, 16'h0000, 2'b11);
    send_check("sat",      16'hF010, 16'h2005, 2'b00, 2'b11, 16'hFF15, 2'b10);
    send_check("sub",      16'h0305, 16'h0503, 2'b00, 2'b10, 16'hFE02, 2'b01);

    // Backpressure: only DEPTH operations fit.
    step();
    out_ready = 1'b0;
    n0 = n_acc;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 2) rand_ops();
      step();
    end
    chk("bp_accepts", n_acc - n0, 2);
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_accept_on_pop", in_ready, 1);

    // Full FIFO streaming: one accept and one pop per cycle.
    n0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      step();
      rand_ops();
    end
    chk("stream_accepts", n_acc - n0, 10);
    in_valid = 1'b0;
    repeat (4) step();

    // Flush with two entries buffered.
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_ops();
    step();
    rand_ops();
    step();
    in_valid = 1'b0;
    on_off = 1'b0;
    step();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_c", c, 0);
    on_off = 1'b1;
    #1;
    chk("flush_ready_back", in_ready, 1);
    chk("flush_no_stale", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset between edges with one entry buffered.
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_ops();
    step();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_c", c, 0);
    chk("arst_in_ready", in_ready, 0);
    step();
    #2;
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    send_check("post_rst_add", 16'h1234, 16'h0001, 2'b00, 2'b00, 16'h1235, 2'b00);

    // Randomised traffic with occasional disable.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      on_off    = ($urandom_range(0, 19) != 0);
      rand_ops();
      step();
    end
    in_valid  = 1'b0;
    on_off    = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    chk("drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/adder_fu_pipe.md
# adder_fu_pipe

Parametrised, lane-split adder functional unit for the `v_tile` datapath, and the successor to the single-cycle tile adder. It accepts operands through a valid/ready handshake and splits the datapath into `LANES` independent SIMD lanes. Each operation is one of add, add-with-carry, subtract or unsigned saturating add. Results are buffered in an output FIFO, so a stalled consumer does not drop results.

## Interface
- `WIDTH`, 16: total operand/result width. Must be divisible by `LANES`.
- `LANES`, 1: number of independent lanes; lane width `LW = WIDTH/LANES`.
- `DEPTH`, 2: output FIFO depth in results. Must be ≥ 1.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `on_off`  in  1: enable. Low means synchronous flush and hold.
- `in_valid`  in  1: operand set present.
- `in_ready`  out  1: unit can accept this cycle.
- `a`, `b`  in  WIDTH: operands. Lane k occupies bits `[k*LW +: LW]`.
- `carry_in`  in  LANES: per-lane carry, used in op 01 only.
- `op`  in  2: 00 add, 01 add+carry, 10 subtract (a−b), 11 saturating add.
- `out_valid`  out  1: FIFO head valid.
- `out_ready`  in  1: consumer takes head.
- `c`  out  WIDTH: FIFO head result.
- `carry_out`  out  LANES: FIFO head per-lane carry/no-borrow flag.
- `ack`  out  1: one-cycle pulse in the cycle after each accepted operation.

## Operation
- Accept condition: `in_valid && in_ready` at a rising edge. On accept, the result is computed combinationally from `a`, `b`, `carry_in` and `op`, then pushed into the FIFO.
- Per-lane arithmetic. Lanes are fully independent, with no carry between lanes. Each lane computes an `LW+1`-bit sum `{co, r}`:
  - op 00: `a + b`.
  - op 01: `a + b + carry_in[k]`.
  - op 10: `a + ~b + 1`. `co = 1` means no borrow (`a >= b`); `r` is the modulo-2^LW difference.
  - op 11: `a + b`. If `co = 1`, `r` is forced to all ones. `co` is reported unchanged.
- `carry_out[k] = co` of lane k. `c` is the concatenation of the lane results.
- FIFO: circular buffer of `DEPTH` entries, each `{c, carry_out}`, with read/write pointers and a count of width `$clog2(DEPTH+1)`. Pointers wrap from `DEPTH-1` to 0.
- `in_ready = on_off && (count < DEPTH || (out_valid && out_ready))`. Push into a full FIFO is permitted in the same cycle as a pop.
- Simultaneous push and pop: count unchanged and both pointers advance. With `count == 0`, a push does not bypass; the result appears next cycle.
- Pop: `out_valid && out_ready` advances the read pointer.
- `on_off` low, sampled at an edge: the FIFO is emptied, pointers and count go to 0, and `ack` goes to 0. While low, `in_ready = 0`, `out_valid = 0`, and stored contents are discarded. No operation is accepted in that cycle.
- `c` and `carry_out` show the head entry while `out_valid = 1`. They are 0 when the FIFO is empty.

## Timing
- Reset (`reset = 0`, asynchronous): count, pointers, `ack`, `out_valid`, `c`, `carry_out` all 0. `in_ready = 0` while reset is asserted.
- After reset release, `in_ready` follows its equation from the first cycle.
- Latency: an operation accepted at edge N gives `out_valid = 1` and its result on `c` from just after edge N. This holds when the FIFO was empty, or when this entry becomes head. `ack = 1` for exactly the cycle following edge N.
- Throughput: one operation per cycle when `out_ready` is held high.
- Backpressure: with `out_ready = 0`, exactly `DEPTH` operations are accepted, then `in_ready` drops.
- Result ordering: results emerge in accept order. The head is stable while `out_valid && !out_ready`.
- Reset asserted mid-stream: all state clears immediately and in-flight results are lost.
- `on_off` and reset have no interaction beyond both clearing state; reset dominates.

## Test plan
- Single op, `WIDTH=16`, `LANES=1`, op 01, a=0xFFFF, b=0x0000, carry_in=1 -> next cycle `c=0x0000`, `carry_out=1`, `ack` pulses for one cycle.
- `LANES=2` (LW=8), op 11, a=0xF010, b=0x2005 -> `c=0xFF15`, `carry_out=2'b10`. Op 10 with a=0x0305, b=0x0503 -> `c=0xFE02`, `carry_out=2'b01`.
- `DEPTH=2`, `out_ready=0`, `in_valid=1` with three distinct operations -> the first two are accepted and `in_ready` falls. Raising `out_ready` returns results in order; the third is accepted in the same cycle as the first pop.
- Full FIFO with `in_valid=1` and `out_ready=1` held for 10 cycles -> `count` stays at 2, one accept and one pop per cycle, no drop or duplication.
- Two entries buffered, then `on_off=0` for one cycle -> next cycle `out_valid=0`, `in_ready=0`, `c=0`. On `on_off=1`, `in_ready=1` and the old results never appear.
- Reset pulsed asynchronously between edges with one entry buffered -> outputs go to 0 immediately. After release, a fresh op 00 with 0x1234 + 0x0001 gives `c=0x1235`.
